// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/halt controller with stall watchdog
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          DRAIN_CYCLES  = 4,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_eret,
  input  logic [31:0] epc,
  input  logic        halt_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        halt_ack,
  output logic        stall_timeout
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    drain_cnt, drain_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
  logic             timeout_q;
  logic             excp_acc;

  // An exception held behind a MEM stall is not taken; MEM keeps it alive.
  assign excp_acc = rst & excp_valid & ~stallreq_mem;

  always_comb begin
    stall = 6'b000000;
    if (!rst || excp_acc)   stall = 6'b000000;
    else if (stallreq_mem)  stall = 6'b011111;
    else if (stallreq_ex)   stall = 6'b001111;
    else if (stallreq_id)   stall = 6'b000111;
    else if (stallreq_if)   stall = 6'b000011;
    else if (state != RUN)  stall = 6'b000011;
  end

  assign flush         = excp_acc;
  assign new_pc        = excp_acc ? (excp_eret ? epc : EXC_VECTOR) : 32'h0;
  assign halt_ack      = (state == HALTED);
  assign stall_timeout = timeout_q;

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (halt_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      DRAIN: begin
        if (!halt_req) begin
          state_nxt = RUN;
        end else if (excp_acc) begin
          // Redirect refills IF, so draining starts over.
          drain_cnt_nxt = '0;
        end else if (stall[5:2] == 4'b0000) begin
          if (drain_cnt == DRAIN_LAST) state_nxt = HALTED;
          else drain_cnt_nxt = drain_cnt + DRAIN_ONE;
        end
      end
      HALTED: begin
        if (!halt_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_nxt = '0;
    if (state == RUN && stall[0] && !flush)
      stall_cnt_nxt = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
      timeout_q <= timeout_q | (stall_cnt == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with cycle model
module tb_pipe_ctrl;

  localparam int DC = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        excp_valid = 1'b0, excp_eret = 1'b0, halt_req = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [5:0]  stall;
  logic        flush, halt_ack, stall_timeout;
  logic [31:0] new_pc;

  int n_chk = 0;
  int n_fail = 0;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .DRAIN_CYCLES(DC), .STALL_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_eret(excp_eret), .epc(epc),
    .halt_req(halt_req),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .halt_ack(halt_ack), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0=running, 1=draining, 2=halted; prog = clean drain cycles seen.
  int m_mode = 0;
  int m_prog = 0;
  int m_wd   = 0;
  bit m_to   = 1'b0;

  function automatic logic exp_flush();
    return rst && excp_valid && !stallreq_mem;
  endfunction

  function automatic logic [5:0] exp_stall();
    if (!rst || exp_flush()) return 6'h00;
    if (stallreq_mem) return 6'h1f;
    if (stallreq_ex)  return 6'h0f;
    if (stallreq_id)  return 6'h07;
    if (stallreq_if)  return 6'h03;
    return (m_mode != 0) ? 6'h03 : 6'h00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0; m_prog <= 0; m_wd <= 0; m_to <= 1'b0;
    end else begin
      m_to <= m_to | (m_wd == TO);
      if (m_mode == 0 && exp_stall() != 6'h00 && !exp_flush())
        m_wd <= (m_wd < TO) ? m_wd + 1 : TO;
      else
        m_wd <= 0;
      if (m_mode == 0) begin
        if (halt_req) begin m_mode <= 1; m_prog <= 0; end
      end else if (m_mode == 1) begin
        if (!halt_req) m_mode <= 0;
        else if (exp_flush()) m_prog <= 0;
        else if (exp_stall() == 6'h03) begin
          m_prog <= m_prog + 1;
          if (m_prog + 1 == DC) m_mode <= 2;
        end
      end else if (!halt_req) begin
        m_mode <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_stall", {26'h0, stall}, {26'h0, exp_stall()});
    chk("cyc_flush", {31'h0, flush}, {31'h0, exp_flush()});
    chk("cyc_new_pc", new_pc, exp_flush() ? (excp_eret ? epc : 32'h20) : 32'h0);
    chk("cyc_halt_ack", {31'h0, halt_ack}, {31'h0, (m_mode == 2)});
    chk("cyc_timeout", {31'h0, stall_timeout}, {31'h0, m_to});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edges_to_ack(output int n);
    n = 0;
    while (!halt_ack && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #3;
    chk("rst_stall", {26'h0, stall}, 32'h0);
    chk("rst_halt_ack", {31'h0, halt_ack}, 32'h0);
    chk("rst_timeout", {31'h0, stall_timeout}, 32'h0);
    tick(2);
    rst = 1'b1;
    tick(1);

    stallreq_id = 1'b1; stallreq_mem = 1'b1; #1;
    chk("prio_mem_id", {26'h0, stall}, 32'h1f);
    stallreq_mem = 1'b0; #1;
    chk("prio_id", {26'h0, stall}, 32'h07);
    stallreq_id = 1'b0; #1;
    chk("prio_none", {26'h0, stall}, 32'h00);
    tick(1);

    excp_valid = 1'b1; #1;
    chk("excp_flush", {31'h0, flush}, 32'h1);
    chk("excp_pc", new_pc, 32'h0000_0020);
    chk("excp_stall", {26'h0, stall}, 32'h0);
    excp_eret = 1'b1; epc = 32'h0040_0010; #1;
    chk("eret_pc", new_pc, 32'h0040_0010);
    stallreq_mem = 1'b1; #1;
    chk("excp_memheld_flush", {31'h0, flush}, 32'h0);
    chk("excp_memheld_stall", {26'h0, stall}, 32'h1f);
    tick(1);
    excp_valid = 1'b0; excp_eret = 1'b0; stallreq_mem = 1'b0;
    tick(1);

    halt_req = 1'b1;
    tick(1);
    chk("drain_stall", {26'h0, stall}, 32'h03);
    edges_to_ack(n);
    chk("halt_clean_edges", n + 1, DC + 1);
    chk("halted_stall", {26'h0, stall}, 32'h03);
    halt_req = 1'b0;
    tick(1);
    chk("unhalt_ack", {31'h0, halt_ack}, 32'h0);
    chk("unhalt_stall", {26'h0, stall}, 32'h0);
    tick(1);

    halt_req = 1'b1;
    tick(2);
    stallreq_ex = 1'b1;
    tick(3);
    stallreq_ex = 1'b0;
    edges_to_ack(n);
    chk("halt_ex_edges", n + 5, 8);
    halt_req = 1'b0;
    tick(2);

    halt_req = 1'b1;
    tick(3);
    excp_valid = 1'b1;
    tick(1);
    excp_valid = 1'b0;
    edges_to_ack(n);
    chk("halt_excp_edges", n + 4, 8);
    halt_req = 1'b0;
    tick(2);

    stallreq_if = 1'b1; tick(7);
    stallreq_if = 1'b0; tick(1);
    stallreq_if = 1'b1; tick(7);
    stallreq_if = 1'b0;
    chk("wd_7_1_7", {31'h0, stall_timeout}, 32'h0);
    tick(1);
    stallreq_if = 1'b1; tick(8);
    chk("wd_8", {31'h0, stall_timeout}, 32'h0);
    tick(1);
    chk("wd_9", {31'h0, stall_timeout}, 32'h1);
    stallreq_if = 1'b0; tick(3);
    chk("wd_sticky", {31'h0, stall_timeout}, 32'h1);

    halt_req = 1'b1;
    tick(3);
    chk("pre_rst_stall", {26'h0, stall}, 32'h03);
    #2 rst = 1'b0;
    #1;
    chk("arst_stall", {26'h0, stall}, 32'h0);
    chk("arst_halt_ack", {31'h0, halt_ack}, 32'h0);
    chk("arst_flush", {31'h0, flush}, 32'h0);
    chk("arst_timeout", {31'h0, stall_timeout}, 32'h0);
    halt_req = 1'b0;
    #10 rst = 1'b1;
    tick(1);
    chk("post_rst_stall", {26'h0, stall}, 32'h0);
    chk("post_rst_ack", {31'h0, halt_ack}, 32'h0);
    halt_req = 1'b1;
    edges_to_ack(n);
    chk("post_rst_halt_edges", n, DC + 1);
    halt_req = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
